byte_access_ram_ctrl: RTL and testbench

Front-end controller placed directly upstream of the team's single-port, byte-write-enable, write-first block RAM (16-bit words, two byte lanes). It accepts byte-addressed read/write requests over a valid/ready handshake and maps each onto a word address plus lane enable. It returns read bytes with a fixed latency. It also provides a hardware clear engine that fills every RAM word with a 16-bit pattern.

---
 rtl/byte_access_ram_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_byte_access_ram_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_access_ram_ctrl.sv
// ---------------------------------------------------------------------------
// byte_access_ram_ctrl
//
// Front-end for a single-port, byte-write-enable, write-first block RAM with
// 16-bit words split into two byte lanes. Byte-addressed host requests arrive
// over a valid/ready handshake. Each request becomes a word address plus a lane
// write enable on a registered RAM bus. Read bytes come back exactly two edges
// after the request is accepted. A clear engine fills every RAM word with a
// latched 16-bit pattern.
//
// Ports
//   CLK, RST      clock (rising edge) and asynchronous active-high reset
//   req_valid     host request valid
//   req_ready     controller can accept (combinational)
//   req_write     1 = byte write, 0 = byte read
//   req_addr      byte address: [ADD_WIDTH:1] word, [0] lane (1 = high byte)
//   req_wdata     write byte
//   rsp_valid     one-cycle pulse, read byte valid
//   rsp_rdata     read byte, held until the next response
//   clr_start     start a clear of the whole RAM
//   clr_pattern   clear word, latched together with clr_start
//   clr_busy      clear in progress
//   ram_we        registered RAM lane write enables
//   ram_addr      registered RAM word address
//   ram_di        registered RAM write data
//   ram_do        RAM registered read data
// ---------------------------------------------------------------------------
module byte_access_ram_ctrl #(
    parameter int SIZE      = 512,
    parameter int ADD_WIDTH = 9,
    parameter int DI_WIDTH  = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADD_WIDTH:0]      req_addr,
    input  logic [DI_WIDTH-1:0]     req_wdata,
    output logic                    rsp_valid,
    output logic [DI_WIDTH-1:0]     rsp_rdata,
    input  logic                    clr_start,
    input  logic [2*DI_WIDTH-1:0]   clr_pattern,
    output logic                    clr_busy,
    output logic [1:0]              ram_we,
    output logic [ADD_WIDTH-1:0]    ram_addr,
    output logic [2*DI_WIDTH-1:0]   ram_di,
    input  logic [2*DI_WIDTH-1:0]   ram_do
);

    // Terminal word of the clear sweep. Compared explicitly so that a depth
    // which is not a power of two still stops at the right word.
    localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(SIZE - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic                   clr_busy_q, clr_busy_d;
    logic [2*DI_WIDTH-1:0]  pattern_q, pattern_d;
    logic [1:0]             ram_we_q, ram_we_d;
    logic [ADD_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [2*DI_WIDTH-1:0]  ram_di_q, ram_di_d;

    // Read pipeline: stage 1 is the cycle the RAM samples the address,
    // stage 2 is the cycle ram_do carries the word.
    logic                   rd_v1_q, rd_v1_d;
    logic                   rd_lane1_q, rd_lane1_d;
    logic                   rd_v2_q, rd_v2_d;
    logic                   rd_lane2_q, rd_lane2_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DI_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;

    logic                   accept;
    logic [2*DI_WIDTH-1:0]  wr_word;
    logic [DI_WIDTH-1:0]    ram_lane [2];

    // A pending clr_start already blocks the handshake, so a simultaneous
    // request is held off and the clear wins.
    assign req_ready = !RST && !clr_busy_q && !clr_start;
    assign accept    = req_valid && req_ready;

    // The write byte is placed on both lanes; the lane enable picks which
    // half of the word actually changes.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign wr_word[gi*DI_WIDTH +: DI_WIDTH] = req_wdata;
            assign ram_lane[gi] = ram_do[gi*DI_WIDTH +: DI_WIDTH];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        clr_busy_d  = clr_busy_q;
        pattern_d   = pattern_q;
        ram_we_d    = 2'b00;
        ram_addr_d  = ram_addr_q;
        ram_di_d    = ram_di_q;

        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d    = ST_CLEAR;
                    clr_busy_d = 1'b1;
                    pattern_d  = clr_pattern;
                    ram_addr_d = '0;
                    ram_we_d   = 2'b11;
                    ram_di_d   = clr_pattern;
                end else if (accept) begin
                    ram_addr_d = req_addr[ADD_WIDTH:1];
                    if (req_write) begin
                        ram_di_d = wr_word;
                        ram_we_d = req_addr[0] ? 2'b10 : 2'b01;
                    end
                end
            end
            ST_CLEAR: begin
                if (ram_addr_q == LAST_ADDR) begin
                    // Last word was written at this edge; release the bus.
                    state_d    = ST_IDLE;
                    clr_busy_d = 1'b0;
                end else begin
                    ram_addr_d = ram_addr_q + ADD_WIDTH'(1);
                    ram_we_d   = 2'b11;
                    ram_di_d   = pattern_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                clr_busy_d = 1'b0;
            end
        endcase

        rd_v1_d     = accept && !req_write;
        rd_lane1_d  = req_addr[0];
        rd_v2_d     = rd_v1_q;
        rd_lane2_d  = rd_lane1_q;
        rsp_valid_d = rd_v2_q;
        rsp_rdata_d = rd_v2_q ? ram_lane[rd_lane2_q] : rsp_rdata_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            clr_busy_q  <= 1'b0;
            pattern_q   <= '0;
            ram_we_q    <= 2'b00;
            ram_addr_q  <= '0;
            ram_di_q    <= '0;
            rd_v1_q     <= 1'b0;
            rd_lane1_q  <= 1'b0;
            rd_v2_q     <= 1'b0;
            rd_lane2_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_busy_q  <= clr_busy_d;
            pattern_q   <= pattern_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_di_q    <= ram_di_d;
            rd_v1_q     <= rd_v1_d;
            rd_lane1_q  <= rd_lane1_d;
            rd_v2_q     <= rd_v2_d;
            rd_lane2_q  <= rd_lane2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign clr_busy  = clr_busy_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_di    = ram_di_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_byte_access_ram_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for byte_access_ram_ctrl. A behavioural write-first byte-enable
// RAM is attached to the RAM bus. A byte-array reference model applies every
// accepted request in order and predicts each read byte and its arrival edge.
// ---------------------------------------------------------------------------
module tb_byte_access_ram_ctrl;

    localparam int SIZE = 512;
    localparam int AW   = 9;
    localparam int DW   = 8;
    localparam int NB   = 2 * SIZE;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_write = 1'b0;
    logic [AW:0]     req_addr = '0;
    logic [DW-1:0]   req_wdata = '0;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            clr_start = 1'b0;
    logic [2*DW-1:0] clr_pattern = '0;
    logic            clr_busy;
    logic [1:0]      ram_we;
    logic [AW-1:0]   ram_addr;
    logic [2*DW-1:0] ram_di;
    logic [2*DW-1:0] ram_do;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    byte_access_ram_ctrl #(.SIZE(SIZE), .ADD_WIDTH(AW), .DI_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .clr_start(clr_start), .clr_pattern(clr_pattern), .clr_busy(clr_busy),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // Write-first, byte-enable block RAM with registered read data.
    logic [2*DW-1:0] ram_arr [0:SIZE-1];
    always @(posedge CLK) begin
        if (ram_we[0]) ram_arr[ram_addr][DW-1:0] <= ram_di[DW-1:0];
        if (ram_we[1]) ram_arr[ram_addr][2*DW-1:DW] <= ram_di[2*DW-1:DW];
        ram_do <= {ram_we[1] ? ram_di[2*DW-1:DW] : ram_arr[ram_addr][2*DW-1:DW],
                   ram_we[0] ? ram_di[DW-1:0]    : ram_arr[ram_addr][DW-1:0]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a flat byte array, updated in acceptance order.
    // ------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic [DW-1:0] model_mem [0:NB-1];
    exp_t          exp_q [$];
    exp_t          e;
    logic [DW-1:0] rsp_log [$];
    int            rsp_edge_log [$];

    // Observed half a cycle after each edge: outputs reflect the last edge,
    // inputs describe what the next edge will accept.
    initial forever begin
        @(negedge CLK);
        if (RST) begin
            exp_q.delete();
            chk("rsp_valid_in_reset", {31'b0, rsp_valid}, 32'd0);
        end else begin
            if (rsp_valid) begin
                rsp_log.push_back(rsp_rdata);
                rsp_edge_log.push_back(edge_cnt);
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", {24'b0, rsp_rdata}, {24'b0, e.data});
                    chk("rsp_edge", edge_cnt, e.due);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
                chk("rsp_missing", {31'b0, rsp_valid}, 32'd1);
                void'(exp_q.pop_front());
            end
            if (clr_start && !clr_busy) begin
                for (int w = 0; w < SIZE; w++) begin
                    model_mem[2*w]   = clr_pattern[DW-1:0];
                    model_mem[2*w+1] = clr_pattern[2*DW-1:DW];
                end
            end
            if (req_valid && req_ready) begin
                if (req_write) begin
                    model_mem[req_addr] = req_wdata;
                end else begin
                    e.data = model_mem[req_addr];
                    e.due  = edge_cnt + 3;   // accepted at the next edge, +2 edges
                    exp_q.push_back(e);
                end
            end
        end
    end

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Presents a request and holds it until it is accepted at an edge.
    task automatic issue(input logic wr, input logic [AW:0] a, input logic [DW-1:0] d);
        bit done;
        done = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge CLK);
            if (req_ready) done = 1'b1;
            tick();
        end
        chk("accept_timeout", {31'b0, done}, 32'd1);
    endtask

    function automatic logic [DW-1:0] log_at(input int i);
        if (i < rsp_log.size()) return rsp_log[i];
        return 'x;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ram_we"},    {30'b0, ram_we}, 32'd0);
        chk({tag, "_ram_addr"},  {23'b0, ram_addr}, 32'd0);
        chk({tag, "_ram_di"},    {16'b0, ram_di}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_rdata"}, {24'b0, rsp_rdata}, 32'd0);
        chk({tag, "_clr_busy"},  {31'b0, clr_busy}, 32'd0);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
    endtask

    task automatic do_clear(input logic [2*DW-1:0] p);
        int s;
        int bad;
        req_valid   = 1'b0;
        clr_start   = 1'b1;
        clr_pattern = p;
        tick();
        clr_start = 1'b0;
        s = edge_cnt;
        chk("clr_busy_start",  {31'b0, clr_busy}, 32'd1);
        chk("clr_we_start",    {30'b0, ram_we}, 32'd3);
        chk("clr_addr_start",  {23'b0, ram_addr}, 32'd0);
        chk("clr_di_start",    {16'b0, ram_di}, {16'b0, p});
        chk("clr_ready_start", {31'b0, req_ready}, 32'd0);
        bad = 0;
        for (int i = 1; i < SIZE; i++) begin
            tick();
            if (ram_addr !== AW'(i) || ram_we !== 2'b11 || clr_busy !== 1'b1) bad++;
        end
        chk("clr_sweep_bad_cycles", bad, 32'd0);
        tick();
        chk("clr_busy_end",  {31'b0, clr_busy}, 32'd0);
        chk("clr_we_end",    {30'b0, ram_we}, 32'd0);
        chk("clr_ready_end", {31'b0, req_ready}, 32'd1);
        chk("clr_busy_edges", edge_cnt - s, SIZE);
    endtask

    // ------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------
    typedef struct {
        logic          wr;
        logic [AW:0]   addr;
        logic [DW-1:0] wdata;
        logic [1:0]    exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int s;
        int acc_edge;
        bit got;
        int n_rd;
        logic [AW:0] a;

        // Lane write/read-back, then a write followed by back-to-back reads.
        // Word 8's high byte still holds the 0xBE of the preceding clear.
        vecs[0] = '{1'b1, 10'h006, 8'hA5, 2'b01, 9'd3, 8'h00};
        vecs[1] = '{1'b1, 10'h007, 8'h3C, 2'b10, 9'd3, 8'h00};
        vecs[2] = '{1'b0, 10'h006, 8'h00, 2'b00, 9'd3, 8'hA5};
        vecs[3] = '{1'b0, 10'h007, 8'h00, 2'b00, 9'd3, 8'h3C};
        vecs[4] = '{1'b1, 10'h010, 8'h11, 2'b01, 9'd8, 8'h00};
        vecs[5] = '{1'b0, 10'h010, 8'h00, 2'b00, 9'd8, 8'h11};
        vecs[6] = '{1'b0, 10'h011, 8'h00, 2'b00, 9'd8, 8'hBE};

        // Power-on reset
        tick();
        tick();
        chk_reset_outputs("por");
        RST = 1'b0;
        #1;
        chk("por_release_ready", {31'b0, req_ready}, 32'd1);
        chk("por_release_rsp",   {31'b0, rsp_valid}, 32'd0);

        // Full clear, then the two top bytes
        do_clear(16'hBEEF);
        rsp_log.delete();
        issue(1'b0, 10'h3FE, 8'h00);
        issue(1'b0, 10'h3FF, 8'h00);
        idle(4);
        chk("clr_rd_count", rsp_log.size(), 32'd2);
        chk("clr_rd_3fe", {24'b0, log_at(0)}, 32'hEF);
        chk("clr_rd_3ff", {24'b0, log_at(1)}, 32'hBE);

        // Table: RAM bus after each accept, read bytes afterwards
        rsp_log.delete();
        rsp_edge_log.delete();
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_we", i),   {30'b0, ram_we}, {30'b0, vecs[i].exp_we});
            chk($sformatf("vec%0d_addr", i), {23'b0, ram_addr}, {23'b0, vecs[i].exp_addr});
            if (vecs[i].wr)
                chk($sformatf("vec%0d_di", i), {16'b0, ram_di}, {16'b0, vecs[i].wdata, vecs[i].wdata});
        end
        idle(4);
        chk("vec_rsp_count", rsp_log.size(), 32'd4);
        n_rd = 0;
        for (int i = 0; i < 7; i++) begin
            if (!vecs[i].wr) begin
                chk($sformatf("vec%0d_rdata", i), {24'b0, log_at(n_rd)}, {24'b0, vecs[i].exp_rd});
                n_rd++;
            end
        end
        if (rsp_edge_log.size() == 4)
            chk("vec_consecutive_rsp", rsp_edge_log[3] - rsp_edge_log[2], 32'd1);

        // Randomised traffic with a clear in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_clear(16'($urandom));
            if ($urandom_range(0, 9) < 2) idle($urandom_range(1, 2));
            if ($urandom_range(0, 3) == 0) a = 10'($urandom);
            else a = 10'($urandom_range(0, 15));
            issue(1'($urandom), a, 8'($urandom));
        end
        idle(4);
        chk("rand_all_rsp_seen", exp_q.size(), 32'd0);

        // Clear and request together; a read accepted one edge earlier
        issue(1'b1, 10'h000, 8'h5A);
        issue(1'b0, 10'h000, 8'h00);
        rsp_log.delete();
        clr_start   = 1'b1;
        clr_pattern = 16'h1234;
        req_write   = 1'b1;
        req_addr    = 10'h000;
        req_wdata   = 8'h77;
        tick();
        clr_start = 1'b0;
        s = edge_cnt;
        chk("simul_busy", {31'b0, clr_busy}, 32'd1);
        got = 1'b0;
        acc_edge = -1;
        for (int i = 0; i < 700 && !got; i++) begin
            @(negedge CLK);
            if (req_ready) begin
                got = 1'b1;
                acc_edge = edge_cnt + 1;
            end
            tick();
        end
        req_valid = 1'b0;
        chk("simul_accept_edge", acc_edge, s + SIZE + 1);
        issue(1'b0, 10'h000, 8'h00);
        issue(1'b0, 10'h001, 8'h00);
        idle(4);
        chk("simul_rsp_count", rsp_log.size(), 32'd3);
        chk("simul_preclear_read", {24'b0, log_at(0)}, 32'h5A);
        chk("simul_write_landed",  {24'b0, log_at(1)}, 32'h77);
        chk("simul_other_lane",    {24'b0, log_at(2)}, 32'h12);

        // Reset in the middle of a clear
        clr_start   = 1'b1;
        clr_pattern = 16'h0F0F;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 99; i++) tick();
        chk("midclr_busy_before", {31'b0, clr_busy}, 32'd1);
        RST = 1'b1;
        #1;
        chk_reset_outputs("midclr");
        tick();
        RST = 1'b0;
        #1;
        chk("midclr_busy_after", {31'b0, clr_busy}, 32'd0);
        do_clear(16'hC3A5);

        // Reset with reads in flight
        issue(1'b1, 10'h020, 8'h9D);
        issue(1'b0, 10'h020, 8'h00);
        issue(1'b0, 10'h021, 8'h00);
        issue(1'b0, 10'h022, 8'h00);
        req_valid = 1'b0;
        RST = 1'b1;
        #1;
        chk_reset_outputs("midrd_0");
        tick();
        tick();
        tick();
        chk_reset_outputs("midrd_3");
        RST = 1'b0;
        #1;
        chk("midrd_release_ready", {31'b0, req_ready}, 32'd1);
        chk("midrd_release_rsp",   {31'b0, rsp_valid}, 32'd0);
        idle(4);
        rsp_log.delete();
        issue(1'b0, 10'h020, 8'h00);
        idle(4);
        chk("midrd_readback", {24'b0, log_at(0)}, 32'h9D);
        chk("final_all_rsp_seen", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
